fifo_to_axis: RTL and testbench

- Downstream drain stage for the stream FIFO: pops words from the FIFO read port and presents them as an AXI4-Stream master.
- A software/control-supplied beat count frames each transfer; TLAST is asserted on the final beat.
- Sits between the FIFO and the DMA stream output.
- Uses a 2-entry output skid buffer so that FIFO pop timing is decoupled from downstream TREADY.

---
 rtl/fifo_to_axis_pkg.sv | 18 +
 rtl/fifo_to_axis_if.sv | 18 +
 rtl/axis_skid_buf.sv | 68 ++++++
 rtl/fifo_to_axis.sv | 97 +++++++++
 tb/tb_fifo_to_axis.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_to_axis_pkg.sv
// Shared definitions for the FIFO-to-AXI-Stream drain stage and its neighbours
// (stream FIFO, DMA control block).
package fifo_to_axis_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fifo_to_axis_if.sv
// AXI4-Stream bundle.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready; once
// tvalid is high, tdata/tlast hold until that edge, and tvalid never depends on tready.
interface fifo_to_axis_if
  import fifo_to_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master(output tdata, output tvalid, output tlast, input tready);
    modport slave(input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry register slice carrying {tlast, tdata}; entry 0 drives the stream
// outputs directly, so all master outputs come straight from flops.
module axis_skid_buf
  import fifo_to_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    fifo_to_axis_if.master        m_axis
);

    logic [DATA_WIDTH:0] ent0;
    logic [DATA_WIDTH:0] ent1;
    logic [1:0]          cnt;
    logic                hs;
    logic                push;
    logic [DATA_WIDTH:0] in_ent;

    assign hs       = (cnt != 2'd0) && m_axis.tready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign in_ready = (cnt != 2'd2) || hs;
    assign push     = in_valid && in_ready;
    assign in_ent   = {in_last, in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        ent0 <= in_ent;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && hs) begin
                        ent0 <= in_ent;
                    end else if (push) begin
                        ent1 <= in_ent;
                        cnt  <= 2'd2;
                    end else if (hs) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (hs) begin
                        ent0 <= ent1;
                        if (push) ent1 <= in_ent;
                        else cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign m_axis.tvalid = (cnt != 2'd0);
    assign m_axis.tlast  = ent0[DATA_WIDTH];
    assign m_axis.tdata  = ent0[DATA_WIDTH-1:0];

endmodule

// File: rtl/fifo_to_axis.sv
// Drains a first-word-fall-through FIFO into an AXI4-Stream master, framing
// each transfer by a beat count and marking the final beat with tlast.
module fifo_to_axis
  import fifo_to_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    fifo_to_axis_if.master        m_axis,
    output logic [1:0]            state_dbg
);

    state_t               state;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] fetch_cnt;
    logic [LEN_WIDTH-1:0] sent_cnt;
    logic                 sb_ready;
    logic                 hs;
    logic                 fetch_last;

    assign hs         = m_axis.tvalid && m_axis.tready;
    assign fetch_last = (fetch_cnt == len - LEN_WIDTH'(1));
    // fetch_cnt < len stops popping at the frame boundary; surplus words stay queued.
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (fetch_cnt < len) && sb_ready;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            len       <= '0;
            fetch_cnt <= '0;
            sent_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        fetch_cnt <= '0;
                        sent_cnt  <= '0;
                        len       <= xfer_len;
                        if (xfer_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_rd_en) fetch_cnt <= fetch_cnt + LEN_WIDTH'(1);
                    if (hs) begin
                        sent_cnt <= sent_cnt + LEN_WIDTH'(1);
                        if (sent_cnt == len - LEN_WIDTH'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .in_valid(fifo_rd_en),
        .in_ready(sb_ready),
        .in_data (fifo_dout),
        .in_last (fetch_last),
        .m_axis  (m_axis)
    );

endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis: FIFO model feeding the DUT, negedge stream
// monitor with an expected-beat queue, one task per scenario.
module tb_fifo_to_axis;
  import fifo_to_axis_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] xfer_len = '0;
  logic          busy;
  logic          done;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic [1:0]    state_dbg;

  fifo_to_axis_if #(.DATA_WIDTH(DW)) m_axis ();

  fifo_to_axis #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .xfer_len  (xfer_len),
    .busy      (busy),
    .done      (done),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .m_axis    (m_axis),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FIFO model (first-word-fall-through)
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr];
  always @(posedge clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

  // scoreboard and monitor
  logic [DW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int sb_bad = 0, stall_bad = 0, over_bad = 0, empty_pop_bad = 0;
  int pop_cnt = 0, hs_cnt = 0, done_cnt = 0, tvalid_cnt = 0, outst = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset) begin
      outst  = 0;
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r &&
          (!m_axis.tvalid || m_axis.tdata !== prev_d || m_axis.tlast !== prev_l)) begin
        stall_bad++;
        $display("FAIL stall_hold: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                 m_axis.tvalid, m_axis.tdata, m_axis.tlast, prev_d, prev_l);
      end
      if (fifo_rd_en && fifo_empty) begin
        empty_pop_bad++;
        $display("FAIL pop_when_empty: got rd_en=1 want 0");
      end
      if (fifo_rd_en) pop_cnt++;
      if (done) done_cnt++;
      if (m_axis.tvalid) tvalid_cnt++;
      outst = outst + (fifo_rd_en ? 1 : 0) - ((m_axis.tvalid && m_axis.tready) ? 1 : 0);
      if (outst > 2) begin
        over_bad++;
        $display("FAIL pop_ahead: got %0d outstanding want <=2", outst);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          sb_bad++;
          $display("FAIL extra_beat: got %0h want none", {m_axis.tlast, m_axis.tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_axis.tlast, m_axis.tdata} !== e) begin
            sb_bad++;
            $display("FAIL beat: got last=%0b data=%0h want last=%0b data=%0h",
                     m_axis.tlast, m_axis.tdata, e[DW], e[DW-1:0]);
          end
        end
      end
      prev_v = m_axis.tvalid;
      prev_r = m_axis.tready;
      prev_d = m_axis.tdata;
      prev_l = m_axis.tlast;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic expect_beat(input logic last, input logic [DW-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    start    = 1'b1;
    xfer_len = len;
    tick();
    start = 1'b0;
  endtask

  // mode 0: tready held high; mode 1: tready pattern 1,0,0,1,0,0,...
  task automatic wait_done(input int budget, input int mode, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      if (mode == 1) m_axis.tready = ((i % 3) == 1);
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
    m_axis.tready = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    m_axis.tready = 1'b1;
    tick();
    tick();
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %0b want 0", m_axis.tvalid); end
    checks++; if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %0b want 0", m_axis.tlast); end
    checks++; if (m_axis.tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %0h want 0", m_axis.tdata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %0b%0b want 00", busy, done); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b want 0", fifo_rd_en); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", state_dbg, ST_IDLE); end
    reset = 1'b0;
    tick();
    checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got state=%0d busy=%0b want 0 0", state_dbg, busy); end
  endtask

  task automatic test_basic();
    int cyc;
    int p0 = pop_cnt;
    int sb0 = sb_bad;
    for (int i = 0; i < 4; i++) push_word(32'h100 + i);
    for (int i = 0; i < 4; i++) expect_beat(i == 3, 32'h100 + i);
    do_start(16'd4);
    checks++; if (busy !== 1'b1 || state_dbg !== ST_RUN) begin errors++; $display("FAIL basic_busy: got busy=%0b state=%0d want 1 %0d", busy, state_dbg, ST_RUN); end
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL basic_first_latency0: got %0b want 0", m_axis.tvalid); end
    tick();
    checks++; if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 32'h100) begin errors++; $display("FAIL basic_first_beat: got v=%0b d=%0h want v=1 d=100", m_axis.tvalid, m_axis.tdata); end
    wait_done(20, 0, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_done_cycle: got %0d want 4", cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL basic_done_width: got done=%0b state=%0d want 0 0", done, state_dbg); end
    checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL basic_pops: got %0d want 4", pop_cnt - p0); end
    checks++; if (sb_bad !== sb0 || exp_q.size() !== 0) begin errors++; $display("FAIL basic_stream: got bad=%0d left=%0d want 0 0", sb_bad - sb0, exp_q.size()); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_fifo_empty: got %0b want 1", fifo_empty); end
  endtask

  task automatic test_overrun();
    int cyc;
    int p0 = pop_cnt;
    int sb0 = sb_bad;
    for (int i = 0; i < 6; i++) push_word(32'h200 + i);
    for (int i = 0; i < 4; i++) expect_beat(i == 3, 32'h200 + i);
    do_start(16'd4);
    wait_done(20, 0, cyc);
    checks++; if (cyc === -1) begin errors++; $display("FAIL ovr_done1: got timeout want done"); end
    tick();
    tick();
    checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL ovr_pops1: got %0d want 4", pop_cnt - p0); end
    checks++; if (wr_ptr - rd_ptr !== 2) begin errors++; $display("FAIL ovr_left: got %0d want 2", wr_ptr - rd_ptr); end
    expect_beat(1'b0, 32'h204);
    expect_beat(1'b1, 32'h205);
    do_start(16'd2);
    wait_done(20, 0, cyc);
    checks++; if (cyc === -1) begin errors++; $display("FAIL ovr_done2: got timeout want done"); end
    checks++; if (pop_cnt - p0 !== 6) begin errors++; $display("FAIL ovr_pops2: got %0d want 6", pop_cnt - p0); end
    checks++; if (sb_bad !== sb0 || exp_q.size() !== 0) begin errors++; $display("FAIL ovr_stream: got bad=%0d left=%0d want 0 0", sb_bad - sb0, exp_q.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    int p0 = pop_cnt;
    int sb0 = sb_bad;
    int st0 = stall_bad;
    int ov0 = over_bad;
    for (int i = 0; i < 8; i++) push_word(32'h300 + i);
    for (int i = 0; i < 8; i++) expect_beat(i == 7, 32'h300 + i);
    do_start(16'd8);
    wait_done(60, 1, cyc);
    checks++; if (cyc === -1) begin errors++; $display("FAIL bp_done: got timeout want done"); end
    checks++; if (stall_bad !== st0) begin errors++; $display("FAIL bp_stable: got %0d violations want 0", stall_bad - st0); end
    checks++; if (over_bad !== ov0) begin errors++; $display("FAIL bp_pop_ahead: got %0d violations want 0", over_bad - ov0); end
    checks++; if (pop_cnt - p0 !== 8) begin errors++; $display("FAIL bp_pops: got %0d want 8", pop_cnt - p0); end
    checks++; if (sb_bad !== sb0 || exp_q.size() !== 0) begin errors++; $display("FAIL bp_stream: got bad=%0d left=%0d want 0 0", sb_bad - sb0, exp_q.size()); end
    tick();
  endtask

  task automatic test_underflow();
    int cyc;
    int d0 = done_cnt;
    int sb0 = sb_bad;
    int ep0 = empty_pop_bad;
    for (int i = 0; i < 3; i++) push_word(32'h400 + i);
    for (int i = 0; i < 5; i++) expect_beat(i == 4, 32'h400 + i);
    do_start(16'd5);
    repeat (10) tick();
    checks++; if (m_axis.tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL uf_gap: got v=%0b busy=%0b want 0 1", m_axis.tvalid, busy); end
    checks++; if (exp_q.size() !== 2) begin errors++; $display("FAIL uf_partial: got %0d pending want 2", exp_q.size()); end
    push_word(32'h403);
    push_word(32'h404);
    wait_done(20, 0, cyc);
    checks++; if (cyc === -1) begin errors++; $display("FAIL uf_done: got timeout want done"); end
    repeat (3) tick();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL uf_done_once: got %0d want 1", done_cnt - d0); end
    checks++; if (empty_pop_bad !== ep0) begin errors++; $display("FAIL uf_empty_pop: got %0d want 0", empty_pop_bad - ep0); end
    checks++; if (sb_bad !== sb0 || exp_q.size() !== 0) begin errors++; $display("FAIL uf_stream: got bad=%0d left=%0d want 0 0", sb_bad - sb0, exp_q.size()); end
  endtask

  task automatic test_zero_len_and_start_hold();
    int cyc;
    int d0 = done_cnt;
    int p0 = pop_cnt;
    int v0 = tvalid_cnt;
    int sb0 = sb_bad;
    do_start(16'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_DONE) begin errors++; $display("FAIL zl_done: got done=%0b busy=%0b state=%0d want 1 0 %0d", done, busy, state_dbg, ST_DONE); end
    tick();
    checks++; if (done !== 1'b0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL zl_back_idle: got done=%0b state=%0d want 0 0", done, state_dbg); end
    repeat (3) tick();
    checks++; if (pop_cnt !== p0 || tvalid_cnt !== v0) begin errors++; $display("FAIL zl_no_access: got pops=%0d valids=%0d want 0 0", pop_cnt - p0, tvalid_cnt - v0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zl_done_once: got %0d want 1", done_cnt - d0); end
    d0 = done_cnt;
    push_word(32'h500);
    push_word(32'h501);
    expect_beat(1'b0, 32'h500);
    expect_beat(1'b1, 32'h501);
    start    = 1'b1;
    xfer_len = 16'd2;
    tick();
    xfer_len = 16'd7;
    tick();
    tick();
    start = 1'b0;
    wait_done(20, 0, cyc);
    checks++; if (cyc === -1) begin errors++; $display("FAIL hold_done: got timeout want done"); end
    repeat (3) tick();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL hold_done_once: got %0d want 1", done_cnt - d0); end
    checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL hold_pops: got %0d want 2", pop_cnt - p0); end
    checks++; if (sb_bad !== sb0 || exp_q.size() !== 0) begin errors++; $display("FAIL hold_stream: got bad=%0d left=%0d want 0 0", sb_bad - sb0, exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int d0 = done_cnt;
    int sb0 = sb_bad;
    for (int i = 0; i < 6; i++) push_word(32'h600 + i);
    expect_beat(1'b0, 32'h600);
    do_start(16'd6);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (m_axis.tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mr_outputs: got v=%0b busy=%0b done=%0b want 0 0 0", m_axis.tvalid, busy, done); end
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mr_no_done: got %0d pulses want 0", done_cnt - d0); end
    checks++; if (wr_ptr - rd_ptr !== 3) begin errors++; $display("FAIL mr_left: got %0d want 3", wr_ptr - rd_ptr); end
    for (int i = 3; i < 6; i++) expect_beat(i == 5, 32'h600 + i);
    do_start(16'd3);
    wait_done(20, 0, cyc);
    checks++; if (cyc === -1) begin errors++; $display("FAIL mr_done: got timeout want done"); end
    checks++; if (sb_bad !== sb0 || exp_q.size() !== 0) begin errors++; $display("FAIL mr_stream: got bad=%0d left=%0d want 0 0", sb_bad - sb0, exp_q.size()); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mr_fifo_empty: got %0b want 1", fifo_empty); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_backpressure();
    test_underflow();
    test_zero_len_and_start_hold();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
